// File: rtl/fix_length_packets2bytes_tx.sv
// Serializes fixed-length Avalon-ST symbol packets into a one-byte-per-beat stream, MSB byte first.
// Checks SOP/EOP framing, pulses err_framing per offending accept, and keeps a saturating error count.
module fix_length_packets2bytes_tx #(
   parameter int SYMBOL_PER_PACKET = 4,
   parameter int BYTES_PER_SYMBOL  = 4,
   parameter int BITS_PER_BYTES    = 8,
   parameter int ERR_CNT_WIDTH     = 4
) (
   input  logic                                       clock_clk,
   input  logic                                       reset_reset,
   input  logic [BYTES_PER_SYMBOL*BITS_PER_BYTES-1:0] asi_in0_data,
   input  logic                                       asi_in0_valid,
   output logic                                       asi_in0_ready,
   input  logic                                       asi_in0_startofpacket,
   input  logic                                       asi_in0_endofpacket,
   output logic [BITS_PER_BYTES-1:0]                  aso_out0_data,
   output logic                                       aso_out0_valid,
   input  logic                                       aso_out0_ready,
   output logic                                       err_framing,
   output logic [ERR_CNT_WIDTH-1:0]                   err_count
);

   localparam int SYM_W  = BYTES_PER_SYMBOL * BITS_PER_BYTES;
   localparam int BIDX_W = $clog2(BYTES_PER_SYMBOL);
   localparam int SIDX_W = $clog2(SYMBOL_PER_PACKET);
   localparam logic [BIDX_W-1:0]        LAST_BYTE = BIDX_W'(BYTES_PER_SYMBOL - 1);
   localparam logic [SIDX_W-1:0]        LAST_SYM  = SIDX_W'(SYMBOL_PER_PACKET - 1);
   localparam logic [SIDX_W-1:0]        FIRST_SYM = SIDX_W'(1);
   localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX   = '1;

   typedef enum logic {S_IDLE = 1'b0, S_IN_PKT = 1'b1} state_t;

   state_t                    r_state, w_state_nxt;
   logic [SIDX_W-1:0]         r_sym_idx, w_sym_idx_nxt;
   logic                      w_ser, w_err;
   logic [SYM_W-1:0]          r_hold;
   logic [BIDX_W-1:0]         r_byte_idx;
   logic [BITS_PER_BYTES-1:0] r_out_data;
   logic                      r_out_valid;
   logic                      r_err;
   logic [ERR_CNT_WIDTH-1:0]  r_err_cnt;
   logic                      w_accept, w_xfer;

   function automatic logic [BITS_PER_BYTES-1:0] pick_byte(input logic [SYM_W-1:0] sym,
                                                           input logic [BIDX_W-1:0] k);
      return sym[(BYTES_PER_SYMBOL - int'(k))*BITS_PER_BYTES-1 -: BITS_PER_BYTES];
   endfunction

   function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] cnt);
      return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
   endfunction

   // The output register doubles as the "holding" flag: a new symbol may enter while the last byte leaves.
   assign asi_in0_ready = !reset_reset &&
                          (!r_out_valid || (aso_out0_ready && (r_byte_idx == LAST_BYTE)));
   assign w_accept      = asi_in0_valid && asi_in0_ready;
   assign w_xfer        = r_out_valid && aso_out0_ready;

   always_ff @(posedge clock_clk) begin
      if (reset_reset) begin
         r_state   <= S_IDLE;
         r_sym_idx <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_sym_idx <= w_sym_idx_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_sym_idx_nxt = r_sym_idx;
      w_ser         = 1'b0;
      w_err         = 1'b0;
      if (w_accept) begin
         case (r_state)
            S_IDLE: begin
               if (!asi_in0_startofpacket) begin
                  w_err = 1'b1;
               end else begin
                  w_ser = 1'b1;
                  if (asi_in0_endofpacket) begin
                     w_err = 1'b1;
                  end else begin
                     w_state_nxt   = S_IN_PKT;
                     w_sym_idx_nxt = FIRST_SYM;
                  end
               end
            end
            S_IN_PKT: begin
               w_ser = 1'b1;
               if (asi_in0_startofpacket) begin
                  w_err         = 1'b1;
                  w_sym_idx_nxt = FIRST_SYM;
               end else if (r_sym_idx == LAST_SYM) begin
                  w_err         = !asi_in0_endofpacket;
                  w_state_nxt   = S_IDLE;
                  w_sym_idx_nxt = '0;
               end else if (asi_in0_endofpacket) begin
                  w_err         = 1'b1;
                  w_state_nxt   = S_IDLE;
                  w_sym_idx_nxt = '0;
               end else begin
                  w_sym_idx_nxt = r_sym_idx + 1'b1;
               end
            end
            default: begin
               w_state_nxt   = S_IDLE;
               w_sym_idx_nxt = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock_clk) begin
      if (w_accept && w_ser) begin
         r_hold <= asi_in0_data;
      end
   end

   always_ff @(posedge clock_clk) begin
      if (reset_reset) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_byte_idx  <= '0;
      end else if (w_accept && w_ser) begin
         r_out_valid <= 1'b1;
         r_out_data  <= pick_byte(asi_in0_data, '0);
         r_byte_idx  <= '0;
      end else if (w_xfer) begin
         if (r_byte_idx == LAST_BYTE) begin
            r_out_valid <= 1'b0;
         end else begin
            r_byte_idx <= r_byte_idx + 1'b1;
            r_out_data <= pick_byte(r_hold, r_byte_idx + 1'b1);
         end
      end
   end

   always_ff @(posedge clock_clk) begin
      if (reset_reset) begin
         r_err     <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         r_err <= w_accept && w_err;
         if (w_accept && w_err) begin
            r_err_cnt <= sat_inc(r_err_cnt);
         end
      end
   end

   assign aso_out0_data  = r_out_data;
   assign aso_out0_valid = r_out_valid;
   assign err_framing    = r_err;
   assign err_count      = r_err_cnt;

endmodule

// File: tb/tb_fix_length_packets2bytes_tx.sv
// Bench for fix_length_packets2bytes_tx: directed and randomized packets against a packet-level
// reference model of the framing rules and MSB-first byte order.
module tb_fix_length_packets2bytes_tx;

   localparam int S       = 4;
   localparam int B       = 4;
   localparam int W       = 8;
   localparam int E       = 4;
   localparam int CNT_MAX = (1 << E) - 1;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [B*W-1:0] in_data = '0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic           in_sop = 1'b0;
   logic           in_eop = 1'b0;
   logic [W-1:0]   out_data;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic           err_framing;
   logic [E-1:0]   err_count;

   always #5 clk = ~clk;

   fix_length_packets2bytes_tx #(
      .SYMBOL_PER_PACKET(S), .BYTES_PER_SYMBOL(B), .BITS_PER_BYTES(W), .ERR_CNT_WIDTH(E)
   ) dut (
      .clock_clk(clk), .reset_reset(rst),
      .asi_in0_data(in_data), .asi_in0_valid(in_valid), .asi_in0_ready(in_ready),
      .asi_in0_startofpacket(in_sop), .asi_in0_endofpacket(in_eop),
      .aso_out0_data(out_data), .aso_out0_valid(out_valid), .aso_out0_ready(out_ready),
      .err_framing(err_framing), .err_count(err_count)
   );

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          bp_mode = 0;
   int          bp_phase = 0;
   logic [W-1:0] got_q[$];
   int          got_cyc[$];
   logic [W-1:0] exp_q[$];
   int          pulses = 0;
   int          exp_pulses = 0;
   int          exp_err_cnt = 0;
   bit          m_in_pkt = 0;
   int          m_cnt = 0;
   bit          chk_ready_en = 0;
   bit          prev_stall = 0;
   logic [W-1:0] prev_data = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // downstream ready: 0 = always, 1 = 1,0,0 repeating, 2 = random, other = held low
   always @(negedge clk) begin
      case (bp_mode)
         0: out_ready = 1'b1;
         1: begin out_ready = (bp_phase % 3 == 0); bp_phase++; end
         2: out_ready = ($urandom_range(0, 3) != 0);
         default: out_ready = 1'b0;
      endcase
   end

   always @(negedge clk) begin
      logic exp_rdy;
      #1;
      if (!rst) begin
         if (prev_stall) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== prev_data) begin
               failures++;
               $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h", out_valid, out_data, prev_data);
            end
         end
         if (chk_ready_en && out_valid === 1'b1) begin
            exp_rdy = out_ready && (got_q.size() % B == B - 1);
            checks++;
            if (in_ready !== exp_rdy) begin
               failures++;
               $display("FAIL ready_timing: asi_in0_ready=%b required %b (byte %0d)", in_ready, exp_rdy, got_q.size());
            end
         end
         if (out_valid === 1'b1 && out_ready) begin
            got_q.push_back(out_data);
            got_cyc.push_back(cyc);
         end
         if (err_framing === 1'b1) pulses++;
      end
      prev_stall = !rst && (out_valid === 1'b1) && !out_ready;
      prev_data  = out_data;
   end

   task automatic model_accept(input logic [B*W-1:0] d, input bit sop, input bit eop);
      bit emit;
      bit err;
      emit = 1; err = 0;
      if (!m_in_pkt) begin
         if (!sop) begin emit = 0; err = 1; end
         else if (eop) err = 1;
         else begin m_in_pkt = 1; m_cnt = 1; end
      end else if (sop) begin
         err = 1; m_cnt = 1;
      end else begin
         m_cnt++;
         if (m_cnt == S) begin m_in_pkt = 0; err = !eop; end
         else if (eop) begin m_in_pkt = 0; err = 1; end
      end
      if (emit) for (int k = 0; k < B; k++) exp_q.push_back(d[(B-k)*W-1 -: W]);
      if (err) begin
         exp_pulses++;
         if (exp_err_cnt < CNT_MAX) exp_err_cnt++;
      end
   endtask

   task automatic send_sym(input logic [B*W-1:0] d, input bit sop, input bit eop, output int acc_cyc);
      int n;
      n = 0;
      @(negedge clk);
      in_data = d; in_valid = 1'b1; in_sop = sop; in_eop = eop;
      #1;
      while (in_ready !== 1'b1 && n < 200) begin
         @(negedge clk); #1; n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL accept_timeout: asi_in0_ready=%b after %0d cycles, required 1", in_ready, n);
         acc_cyc = -1;
         in_valid = 1'b0;
      end else begin
         acc_cyc = cyc;
         model_accept(d, sop, eop);
         @(posedge clk);
      end
   endtask

   task automatic idle_in();
      @(negedge clk);
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      @(negedge clk); #2;
      while (out_valid === 1'b1 && n < 300) begin
         @(negedge clk); #2; n++;
      end
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL drain_timeout: aso_out0_valid=%b, required 0", out_valid);
      end
      @(negedge clk); #2;
   endtask

   task automatic clear_obs();
      got_q.delete(); got_cyc.delete(); exp_q.delete();
      pulses = 0; exp_pulses = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      m_in_pkt = 0; m_cnt = 0; exp_err_cnt = 0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #2;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: %b required 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: %b required 0", out_valid); end
      checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_data: %h required 00", out_data); end
      checks++; if (err_framing !== 1'b0) begin failures++; $display("FAIL reset_err: %b required 0", err_framing); end
      checks++; if (err_count !== '0) begin failures++; $display("FAIL reset_cnt: %0d required 0", err_count); end
      @(negedge clk);
      rst = 1'b0;
      #2;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready: %b required 1", in_ready); end
   endtask

   task automatic run_nominal_packet(input string tag);
      int a0;
      int a;
      logic [B*W-1:0] syms [S];
      syms = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
      clear_obs();
      chk_ready_en = 1;
      send_sym(syms[0], 1'b1, 1'b0, a0);
      for (int i = 1; i < S; i++) send_sym(syms[i], 1'b0, i == S - 1, a);
      idle_in();
      drain();
      chk_ready_en = 0;
      checks++;
      if (got_q.size() != S * B) begin
         failures++;
         $display("FAIL %s_count: %0d bytes, required %0d", tag, got_q.size(), S * B);
      end
      for (int i = 0; i < got_q.size() && i < S * B; i++) begin
         checks++;
         if (got_q[i] !== 8'(i) || got_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL %s_byte%0d: %h required %h", tag, i, got_q[i], 8'(i));
         end
      end
      if (bp_mode == 0) begin
         for (int i = 0; i < got_cyc.size(); i++) begin
            checks++;
            if (got_cyc[i] != a0 + 1 + i) begin
               failures++;
               $display("FAIL %s_latency%0d: cycle %0d required %0d", tag, i, got_cyc[i], a0 + 1 + i);
            end
         end
      end
      checks++; if (pulses != 0) begin failures++; $display("FAIL %s_pulses: %0d required 0", tag, pulses); end
      checks++; if (err_count !== '0) begin failures++; $display("FAIL %s_errcnt: %0d required 0", tag, err_count); end
   endtask

   task automatic test_nominal();
      bp_mode = 0;
      run_nominal_packet("nominal");
   endtask

   task automatic test_backpressure();
      bp_phase = 0;
      bp_mode = 1;
      run_nominal_packet("backpressure");
      bp_mode = 0;
   endtask

   task automatic test_missing_sop();
      int a;
      clear_obs();
      send_sym(32'hDEADBEEF, 1'b0, 1'b0, a);
      idle_in(); #2;
      checks++; if (err_framing !== 1'b1) begin failures++; $display("FAIL nosop_pulse: %b required 1", err_framing); end
      @(negedge clk); #2;
      checks++; if (err_framing !== 1'b0) begin failures++; $display("FAIL nosop_pulse_end: %b required 0", err_framing); end
      checks++; if (out_valid !== 1'b0 || got_q.size() != 0) begin
         failures++; $display("FAIL nosop_dropped: valid=%b bytes=%0d required 0/0", out_valid, got_q.size());
      end
      checks++; if (err_count !== 4'd1) begin failures++; $display("FAIL nosop_errcnt: %0d required 1", err_count); end
      send_sym($urandom(), 1'b1, 1'b0, a);
      for (int i = 1; i < S; i++) send_sym($urandom(), 1'b0, i == S - 1, a);
      idle_in();
      drain();
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL nosop_follow_count: %0d required %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL nosop_follow_byte%0d: %h required %h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (pulses != 1) begin failures++; $display("FAIL nosop_pulses: %0d required 1", pulses); end
      checks++; if (err_count !== E'(exp_err_cnt)) begin failures++; $display("FAIL nosop_errcnt2: %0d required %0d", err_count, exp_err_cnt); end
   endtask

   task automatic test_early_eop();
      int a;
      logic [W-1:0] ee [8];
      ee = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      clear_obs();
      send_sym(32'h11223344, 1'b1, 1'b0, a);
      send_sym(32'h55667788, 1'b0, 1'b1, a);
      send_sym($urandom(), 1'b1, 1'b0, a);
      for (int i = 1; i < S; i++) send_sym($urandom(), 1'b0, i == S - 1, a);
      idle_in();
      drain();
      for (int i = 0; i < 8 && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== ee[i]) begin failures++; $display("FAIL early_eop_byte%0d: %h required %h", i, got_q[i], ee[i]); end
      end
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL early_eop_count: %0d required %0d", got_q.size(), exp_q.size()); end
      for (int i = 8; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL early_eop_next_byte%0d: %h required %h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (pulses != 1) begin failures++; $display("FAIL early_eop_pulses: %0d required 1", pulses); end
      checks++; if (err_count !== E'(exp_err_cnt)) begin failures++; $display("FAIL early_eop_errcnt: %0d required %0d", err_count, exp_err_cnt); end
   endtask

   task automatic test_random();
      int a;
      int len;
      bit sop;
      bit eop;
      clear_obs();
      bp_mode = 2;
      for (int p = 0; p < 12; p++) begin
         len = $urandom_range(1, S + 1);
         for (int i = 0; i < len; i++) begin
            sop = (i == 0);
            eop = (i == len - 1);
            if ($urandom_range(0, 7) == 0) sop = ~sop;
            if ($urandom_range(0, 7) == 0) eop = ~eop;
            send_sym($urandom(), sop, eop, a);
         end
         if ($urandom_range(0, 1) == 1) idle_in();
      end
      idle_in();
      drain();
      bp_mode = 0;
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL random_count: %0d required %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL random_byte%0d: %h required %h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (pulses != exp_pulses) begin failures++; $display("FAIL random_pulses: %0d required %0d", pulses, exp_pulses); end
      checks++; if (err_count !== E'(exp_err_cnt)) begin failures++; $display("FAIL random_errcnt: %0d required %0d", err_count, exp_err_cnt); end
   endtask

   task automatic test_saturation();
      int a;
      do_reset();
      clear_obs();
      for (int i = 0; i < 17; i++) send_sym($urandom(), 1'b0, 1'b0, a);
      idle_in();
      drain();
      checks++; if (err_count !== E'(CNT_MAX) || exp_err_cnt != CNT_MAX) begin
         failures++; $display("FAIL sat_errcnt: %0d required %0d", err_count, CNT_MAX);
      end
      checks++; if (pulses != 17) begin failures++; $display("FAIL sat_pulses: %0d required 17", pulses); end
      checks++; if (got_q.size() != 0) begin failures++; $display("FAIL sat_bytes: %0d required 0", got_q.size()); end
   endtask

   task automatic test_reset_mid();
      int a;
      clear_obs();
      bp_mode = 0;
      send_sym(32'hAABBCCDD, 1'b1, 1'b0, a);
      #1 in_valid = 1'b0; in_sop = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      bp_mode = 3;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk); #2;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid: %b required 0", out_valid); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL midrst_ready: %b required 0", in_ready); end
      rst = 1'b0;
      bp_mode = 0;
      m_in_pkt = 0; m_cnt = 0; exp_err_cnt = 0;
      @(negedge clk); #2;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready_after: %b required 1", in_ready); end
      checks++; if (err_count !== '0) begin failures++; $display("FAIL midrst_errcnt: %0d required 0", err_count); end
      repeat (5) @(negedge clk);
      #2;
      checks++; if (got_q.size() != 2) begin failures++; $display("FAIL midrst_count: %0d bytes required 2", got_q.size()); end
      if (got_q.size() >= 2) begin
         checks++; if (got_q[0] !== 8'hAA || got_q[1] !== 8'hBB) begin
            failures++; $display("FAIL midrst_bytes: %h %h required aa bb", got_q[0], got_q[1]);
         end
      end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_idle: %b required 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_backpressure();
      test_missing_sop();
      test_early_eop();
      test_random();
      test_saturation();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
